// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map
// and the vector arithmetic used by the top level.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [7:0] ADDR_IER  = 8'h5D;
    localparam logic [7:0] ADDR_IPR  = 8'h5E;
    localparam logic [7:0] ADDR_CTRL = 8'h5F;

    localparam int GIE_BIT = 7;

    // Vectors are spaced two apart and wrap modulo 256.
    function automatic logic [7:0] src_vector(input logic [7:0] base, input logic [2:0] idx);
        return base + {4'b0000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over NUM_SRC request bits.
module irq_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [2:0]         idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Walk downwards so the lowest set index is the last one to assign.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: edge-detected pending flags, per-source and
// global enables, and a one-at-a-time IDLE/REQ/SERVICE handshake with the CPU.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int         NUM_SRC  = 4,
    parameter logic [7:0] VEC_BASE = 8'h02
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         addr,
    input  logic               write,
    input  logic               read,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    input  logic [NUM_SRC-1:0] src_req,
    output logic [NUM_SRC-1:0] src_exec,
    output logic               cpu_irq,
    output logic [7:0]         cpu_vector,
    input  logic               cpu_ack,
    input  logic               cpu_reti
);

    logic [NUM_SRC-1:0] req_prev_reg;
    logic [NUM_SRC-1:0] ier_reg;
    logic [NUM_SRC-1:0] ipr_reg;
    logic [NUM_SRC-1:0] ipr_next;
    logic [NUM_SRC-1:0] req_rise;
    logic [NUM_SRC-1:0] ipr_clr;
    logic [NUM_SRC-1:0] win_mask;
    logic               gie_reg;
    logic [2:0]         last_reg;
    logic [2:0]         win_reg;
    irq_state_t         state_reg;

    logic               pend_valid;
    logic [2:0]         pend_idx;
    logic [7:0]         rd_value;

    logic wr_ier;
    logic wr_ipr;
    logic wr_ctrl;
    logic ack_fire;

    assign wr_ier   = write && (addr == ADDR_IER);
    assign wr_ipr   = write && (addr == ADDR_IPR);
    assign wr_ctrl  = write && (addr == ADDR_CTRL);
    assign ack_fire = (state_reg == REQ) && cpu_ack;
    assign req_rise = src_req & ~req_prev_reg;

    // Per-bit pending update: a fresh rising edge beats any clear in the same cycle.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign win_mask[gi] = (win_reg == 3'(gi));
            assign ipr_clr[gi]  = (wr_ipr && wdata[gi]) || (ack_fire && win_mask[gi]);
            assign ipr_next[gi] = req_rise[gi] | (ipr_reg[gi] & ~ipr_clr[gi]);
        end
    endgenerate

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (ipr_reg & ier_reg),
        .valid (pend_valid),
        .idx   (pend_idx)
    );

    always_comb begin
        rd_value = 8'h00;
        case (addr)
            ADDR_IER:  rd_value = 8'(ier_reg);
            ADDR_IPR:  rd_value = 8'(ipr_reg);
            ADDR_CTRL: rd_value = {gie_reg, 4'b0000, last_reg};
            default:   rd_value = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_prev_reg <= '0;
            ipr_reg      <= '0;
            ier_reg      <= '0;
            rdata        <= 8'h00;
        end else begin
            req_prev_reg <= src_req;
            ipr_reg      <= ipr_next;
            if (wr_ier) begin
                ier_reg <= wdata[NUM_SRC-1:0];
            end
            if (read && !write) begin
                rdata <= rd_value;
            end
        end
    end

    // Handshake FSM; the FSM's own GIE updates override a same-cycle software write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            gie_reg    <= 1'b0;
            last_reg   <= 3'd0;
            win_reg    <= 3'd0;
            cpu_irq    <= 1'b0;
            cpu_vector <= 8'h00;
            src_exec   <= '0;
        end else begin
            src_exec <= '0;
            if (wr_ctrl) begin
                gie_reg <= wdata[GIE_BIT];
            end
            case (state_reg)
                IDLE: begin
                    if (gie_reg && pend_valid) begin
                        win_reg    <= pend_idx;
                        cpu_irq    <= 1'b1;
                        cpu_vector <= src_vector(VEC_BASE, pend_idx);
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (cpu_ack) begin
                        cpu_irq   <= 1'b0;
                        gie_reg   <= 1'b0;
                        last_reg  <= win_reg;
                        src_exec  <= win_mask;
                        state_reg <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (cpu_reti) begin
                        gie_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is observed.
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic       write;
    logic       read;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [3:0] src_req;
    logic [3:0] src_exec;
    logic       cpu_irq;
    logic [7:0] cpu_vector;
    logic       cpu_ack;
    logic       cpu_reti;

    int tests_run;
    int tests_failed;
    logic [7:0] exp_q[$];

    irq_ctrl #(
        .NUM_SRC  (4),
        .VEC_BASE (8'h02)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .write      (write),
        .read       (read),
        .wdata      (wdata),
        .rdata      (rdata),
        .src_req    (src_req),
        .src_exec   (src_exec),
        .cpu_irq    (cpu_irq),
        .cpu_vector (cpu_vector),
        .cpu_ack    (cpu_ack),
        .cpu_reti   (cpu_reti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %02h", tag, got);
        end
    endtask

    task automatic expect_push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic expect_pop(input string tag, input logic [7:0] got);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            check(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        read = 1'b1;
        expect_push(exp);
        tick();
        read = 1'b0;
        expect_pop(tag, rdata);
    endtask

    task automatic wait_irq(input string tag, input logic [7:0] exp_vec);
        expect_push(exp_vec);
        for (int i = 0; i < 20; i++) begin
            if (cpu_irq) break;
            tick();
        end
        check({tag, "_irq"}, 8'(cpu_irq), 8'h01);
        expect_pop({tag, "_vec"}, cpu_vector);
    endtask

    task automatic do_ack(input string tag, input logic [3:0] exp_exec);
        cpu_ack = 1'b1;
        expect_push(8'(exp_exec));
        tick();
        cpu_ack = 1'b0;
        check({tag, "_irq_low"}, 8'(cpu_irq), 8'h00);
        expect_pop({tag, "_exec"}, 8'(src_exec));
        tick();
        check({tag, "_exec_end"}, 8'(src_exec), 8'h00);
    endtask

    task automatic do_reti();
        cpu_reti = 1'b1;
        tick();
        cpu_reti = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        addr     = 8'h00;
        write    = 1'b0;
        read     = 1'b0;
        wdata    = 8'h00;
        src_req  = 4'h0;
        cpu_ack  = 1'b0;
        cpu_reti = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_irq", 8'(cpu_irq), 8'h00);
        check("rst_vec", cpu_vector, 8'h00);
        check("rst_exec", 8'(src_exec), 8'h00);
        check("rst_rdata", rdata, 8'h00);
        rst = 1'b1;
        tick();
        reg_read("rst_ier", 8'h5D, 8'h00);
        reg_read("rst_ipr", 8'h5E, 8'h00);
        reg_read("rst_ctrl", 8'h5F, 8'h00);
        reg_read("unmapped", 8'h20, 8'h00);

        // Single source, exact latency, held level
        reg_write(8'h5D, 8'h01);
        reg_write(8'h5F, 8'h80);
        reg_read("ier_rb", 8'h5D, 8'h01);
        src_req = 4'b0001;
        tick();
        check("lat_edge_k", 8'(cpu_irq), 8'h00);
        expect_push(8'h02);
        tick();
        check("lat_edge_k1", 8'(cpu_irq), 8'h01);
        expect_pop("s0_vec", cpu_vector);
        do_ack("s0", 4'b0001);
        reg_read("s0_ipr", 8'h5E, 8'h00);
        reg_read("s0_ctrl", 8'h5F, 8'h00);
        do_reti();
        for (int i = 0; i < 5; i++) tick();
        check("held_no_retrig", 8'(cpu_irq), 8'h00);
        reg_read("s0_ctrl_reti", 8'h5F, 8'h80);

        // Two sources at once, priority order
        reg_write(8'h5D, 8'h0F);
        src_req = 4'b1010;
        wait_irq("p1", 8'h04);
        do_ack("p1", 4'b0010);
        reg_read("p1_ctrl", 8'h5F, 8'h01);
        do_reti();
        check("p_gap_after_reti", 8'(cpu_irq), 8'h00);
        tick();
        check("p3_irq_r1", 8'(cpu_irq), 8'h01);
        wait_irq("p3", 8'h08);
        do_ack("p3", 4'b1000);
        reg_read("p3_ctrl", 8'h5F, 8'h03);
        do_reti();
        src_req = 4'h0;
        tick();

        // GIE off: pending only, W1C, then GIE on with nothing pending
        reg_write(8'h5F, 8'h00);
        src_req = 4'b0100;
        tick();
        src_req = 4'h0;
        for (int i = 0; i < 3; i++) tick();
        check("gie0_no_irq", 8'(cpu_irq), 8'h00);
        reg_read("gie0_ipr", 8'h5E, 8'h04);
        reg_write(8'h5E, 8'h04);
        reg_read("w1c_ipr", 8'h5E, 8'h00);
        reg_write(8'h5F, 8'h80);
        for (int i = 0; i < 3; i++) tick();
        check("gie1_no_irq", 8'(cpu_irq), 8'h00);

        // No retraction while in REQ
        src_req = 4'b0001;
        tick();
        src_req = 4'h0;
        wait_irq("nr", 8'h02);
        reg_write(8'h5F, 8'h00);
        reg_write(8'h5D, 8'h00);
        reg_write(8'h5E, 8'h0F);
        check("nr_irq_held", 8'(cpu_irq), 8'h01);
        check("nr_vec_held", cpu_vector, 8'h02);
        do_ack("nr", 4'b0001);
        do_reti();
        reg_read("nr_ctrl", 8'h5F, 8'h80);
        reg_write(8'h5D, 8'h0F);

        // Ack outside REQ is ignored
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check("stray_ack_exec", 8'(src_exec), 8'h00);

        // Asynchronous reset while in REQ
        src_req = 4'b0010;
        tick();
        src_req = 4'h0;
        wait_irq("ar", 8'h04);
        #2;
        rst = 1'b0;
        #1;
        check("ar_irq_async", 8'(cpu_irq), 8'h00);
        check("ar_vec_async", cpu_vector, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        reg_read("ar_ier", 8'h5D, 8'h00);
        reg_read("ar_ipr", 8'h5E, 8'h00);
        reg_read("ar_ctrl", 8'h5F, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        check("ar_no_irq", 8'(cpu_irq), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
